// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/[parity]/stop frame receiver with a one-deep valid/ready output register.
// Optional parity bit and check compiled in with SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int N = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         busy,
  output logic         frame_err,
  output logic         parity_err,
  output logic         overrun
);
  localparam int CW = $clog2(N);
`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [N-1:0] shreg;
  logic last, par_ok, accept;
  assign last   = cnt == CW'(N - 1);
  assign busy   = state != IDLE;
  assign accept = out_valid && out_ready;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_bit;
  assign par_ok = (^{shreg, par_bit}) == PARITY_ODD;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0 & PARITY_ODD;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = serial_in ? DATA : IDLE;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      DATA:   state_n = last ? PARITY : DATA;
      PARITY: state_n = STOP;
`else
      DATA:   state_n = last ? STOP : DATA;
`endif
      STOP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (accept) out_valid <= 1'b0;
      case (state)
        IDLE: cnt <= '0;
        DATA: begin
          shreg <= {shreg[N-2:0], serial_in};
          cnt   <= cnt + 1'b1;
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY: par_bit <= serial_in;
`endif
        STOP: begin
          // a bad stop bit masks any parity failure
          if (serial_in) frame_err <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          else if (!par_ok) parity_err <= 1'b1;
`endif
          else if (!out_valid || out_ready) begin
            out_data  <= shreg;
            out_valid <= 1'b1;
          end else overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`ifndef SERIAL_FRAME_RX_PARITY_EN
  logic unused_par;
  assign unused_par = par_ok;
`endif
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames plus randomized traffic checked every cycle against a frame-level model.
module tb_serial_frame_rx;
  localparam int N = 8;
  localparam bit PODD = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, serial_in = 1'b0, out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic out_valid, busy, frame_err, parity_err, overrun;
  serial_frame_rx #(.N(N), .PARITY_ODD(PODD)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  int kind = 0, rdy_mode = 0;
  logic [N-1:0] fdata = '0;
  logic fpar = 1'b0;
  logic m_valid, m_busy, m_ferr, m_perr, m_ovr, acc, load, par_ok;
  logic [N-1:0] m_data;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // kind tags what the bench means the sampled bit to be: 0 idle, 1 start, 2 data, 3 parity, 4 stop
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_busy = 1'b0;
      m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    end else begin
      acc = m_valid && out_ready;
      load = 1'b0;
      m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
      par_ok = PEN ? (($countones({fdata, fpar}) % 2) == int'(PODD)) : 1'b1;
      if (kind == 1) m_busy = 1'b1;
      if (kind == 4) begin
        m_busy = 1'b0;
        if (serial_in) m_ferr = 1'b1;
        else if (!par_ok) m_perr = 1'b1;
        else if (!m_valid || out_ready) begin load = 1'b1; m_data = fdata; end
        else m_ovr = 1'b1;
      end
      m_valid = load ? 1'b1 : (acc ? 1'b0 : m_valid);
    end
  end
  always @(negedge clk) if (!reset) begin
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("busy", busy, m_busy);
    chk("frame_err", frame_err, m_ferr);
    chk("parity_err", parity_err, m_perr);
    chk("overrun", overrun, m_ovr);
  end
  task automatic send_bit(logic b, int k);
    serial_in = b;
    kind = k;
    if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(logic [N-1:0] d, logic stop, logic pflip, int stop_rdy);
    fdata = d;
    fpar = (^d) ^ PODD ^ pflip;
    send_bit(1'b1, 1);
    for (int i = N - 1; i >= 0; i--) send_bit(d[i], 2);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_bit(fpar, 3);
`endif
    if (stop_rdy >= 0) out_ready = stop_rdy[0];
    send_bit(stop, 4);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    serial_in = 1'b0;
    kind = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun, 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    #1 do_reset();
    out_ready = 1'b1;
    repeat (3) send_bit(1'b0, 0);
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    chk("a5_data", out_data, 32'hA5);
    chk("a5_valid", out_valid, 1);
    send_bit(1'b0, 0);
    chk("a5_consumed", out_valid, 0);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    chk("5a_ferr", frame_err, 1);
    chk("5a_valid", out_valid, 0);
    chk("5a_idle", busy, 0);
    send_bit(1'b0, 0);
    chk("5a_ferr_off", frame_err, 0);
    chk("5a_still_idle", busy, 0);
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, -1);
    chk("11_data", out_data, 32'h11);
    send_frame(8'h22, 1'b0, 1'b0, -1);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_held", out_data, 32'h11);
    chk("ovr_valid", out_valid, 1);
    out_ready = 1'b1;
    send_bit(1'b0, 0);
    chk("ovr_drain", out_valid, 0);
    chk("ovr_off", overrun, 0);
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b0, 1'b0, 1);
    chk("same_edge_data", out_data, 32'h22);
    chk("same_edge_valid", out_valid, 1);
    chk("same_edge_no_ovr", overrun, 0);
    out_ready = 1'b0;
    fdata = 8'hFF;
    send_bit(1'b1, 1);
    repeat (4) send_bit(1'b1, 2);
    do_reset();
    out_ready = 1'b1;
    send_bit(1'b0, 0);
    send_frame(8'h81, 1'b0, 1'b0, -1);
    chk("81_data", out_data, 32'h81);
    chk("81_valid", out_valid, 1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_frame(8'h03, 1'b0, 1'b0, -1);
    chk("par_good", out_data, 32'h03);
    send_frame(8'h03, 1'b0, 1'b1, -1);
    chk("par_err", parity_err, 1);
    chk("par_valid", out_valid, 0);
`endif
    repeat (250) begin
      rdy_mode = $urandom_range(0, 2);
      if (rdy_mode < 2) out_ready = rdy_mode[0];
      repeat ($urandom_range(0, 3)) send_bit(1'b0, 0);
      if ($urandom_range(0, 29) == 0) begin
        fdata = N'($urandom);
        send_bit(1'b1, 1);
        repeat ($urandom_range(0, N - 1)) send_bit(1'($urandom_range(0, 1)), 2);
        do_reset();
      end else
        send_frame(N'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, -1);
    end
    rdy_mode = 0;
    out_ready = 1'b1;
    repeat (3) send_bit(1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter N, default 8, data bits per frame (N >= 2).
REQ-002 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity (used only when parity is compiled in).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 serial_in  input  1  bit stream from the upstream shift register, one bit per clock.
REQ-006 out_data  output  N  last good frame payload.
REQ-007 out_valid  output  1  out_data holds an unconsumed frame.
REQ-008 out_ready  input  1  consumer accepts out_data when out_valid && out_ready at a rising edge.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit was not 0.
REQ-011 parity_err  output  1  one-cycle pulse: parity check failed.
REQ-012 overrun  output  1  one-cycle pulse: good frame dropped because out_valid was high and not accepted.

Function
REQ-013 The line SHALL idle low; frame = start bit (1), N data bits MSB first, optional parity bit, stop bit (0).
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: serial_in=1 sampled SHALL move to DATA with bit counter cleared; serial_in=0 SHALL keep IDLE.
REQ-016 DATA: each edge SHALL shift serial_in into an N-bit shift register LSB-in and increment the counter; on the Nth bit SHALL move to PARITY (if compiled) else STOP.
REQ-017 PARITY: one edge SHALL capture the parity bit, then SHALL move to STOP.
REQ-018 STOP: one edge SHALL sample the stop bit and SHALL return to IDLE unconditionally; a 1 sampled here SHALL NOT be treated as a start bit.
REQ-019 A frame SHALL be good when stop bit = 0 and (parity not compiled or parity correct).
REQ-020 Good frame with out_valid=0, or with out_valid=1 and out_ready=1 on the same edge, SHALL load out_data and set out_valid at the edge sampling the stop bit.
REQ-021 Good frame with out_valid=1 and out_ready=0 SHALL be discarded, out_data unchanged, overrun pulsed for the following cycle.
REQ-022 Bad stop bit SHALL pulse frame_err and discard the frame; if parity also fails, only frame_err SHALL pulse.
REQ-023 Parity failure with correct stop bit SHALL pulse parity_err and discard the frame.
REQ-024 out_valid SHALL clear on an accepting edge unless a new good frame loads on that same edge.
REQ-025 out_data SHALL remain stable while out_valid=1 and not accepted.
REQ-026 A new start bit SHALL be accepted on the edge immediately after STOP (back-to-back frames, period N+2 or N+3 cycles).
REQ-027 Error/overrun pulses SHALL be registered, exactly one cycle wide, asserted the cycle after the STOP sample edge.

Reset
REQ-028 reset SHALL immediately force IDLE, counter 0, shift register 0, out_data 0, out_valid 0, busy 0, frame_err 0, parity_err 0, overrun 0.
REQ-029 reset mid-frame SHALL discard the partial frame and any held out_data; reception resumes with the next start bit after reset deasserts.

Configuration
REQ-030 Macro SERIAL_FRAME_RX_PARITY_EN defined: PARITY state present, frame N+3 bits, parity per PARITY_ODD checked over data bits plus parity bit.
REQ-031 Macro undefined: PARITY state and parity logic absent, frame N+2 bits, parity_err tied 0.

Verification
REQ-032 No parity, N=8: idle 0s, then 1, 0xA5 MSB first, 0, out_ready=1 -> out_data=0xA5, out_valid=1 for one cycle after stop edge.
REQ-033 Parity even: frame 1, 0x03, parity 0, stop 0 -> out_data=0x03; same with parity 1 -> parity_err pulse, out_valid stays 0.
REQ-034 Frame 0x5A with stop bit 1 -> frame_err one-cycle pulse, out_valid 0, FSM back in IDLE, following 1 not taken as start.
REQ-035 out_ready=0, frames 0x11 then 0x22 back-to-back -> out_data=0x11 held, overrun pulse after second frame; out_ready=1 then -> out_valid falls.
REQ-036 Second frame's stop edge coincides with out_ready=1 -> out_data=0x22, out_valid stays 1, no overrun.
REQ-037 reset asserted after 4 data bits of 0xFF -> all outputs 0 immediately; next full frame 0x81 received correctly.
